ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the 159-bit decode bundle produced by the decode stage and registers it.
- Computes the ALU result and issues the data-SRAM request (enable, byte-write mask, address, write data).
- Owns the HI/LO registers, a combinational multiplier and an iterative 32-cycle divider; requests a pipeline stall while a divide is in flight.
- Forwards its result back to decode and passes an 82-bit bundle to MEM.

Parameters:
- ID_TO_EX_WD, 159, input bundle width (shared define).
- EX_TO_MEM_WD, 82, output bundle width (shared define).
- EX_TO_ID_WD, 39, forwarding bundle width (shared define).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low (asserted when 0).
- stall  in  6  global stall vector; bit 2 = EX, bit 3 = MEM; 1 = Stop.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
- stallreq_for_ex  out  1  divide not yet complete.
- ex_to_mem_bus  out  82  {pc, opcode[5:0], ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr, result}.
- ex_to_id_bus  out  39  {is_load, rf_we, rf_waddr, result}.
- data_sram_en  out  1  memory access.
- data_sram_wen  out  4  byte write mask.
- data_sram_addr  out  32  rdata1 + sext(imm).
- data_sram_wdata  out  32  store data, lane-replicated.

Behaviour:
Pipeline register
- On reset, the pipeline register is cleared to 0.
- stall[2]=1 and stall[3]=0: load a bubble (all zero).
- stall[2]=0: load id_to_ex_bus.
- Otherwise: hold.

ALU operand selection (one-hot selects)
- src1: [0] rdata1; [1] pc; [2] zero-extended inst[10:6].
- src2: [0] rdata2; [1] sign-extended imm16; [2] 32'd8; [3] zero-extended imm16.
- No select bit set: operand is 0.

ALU operations
- alu_op bit order, MSB to LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shift amount is src1[4:0]; the shifted value is src2.
- lui result = {src2[15:0], 16'h0}.
- No op bit set: result 0.
- No overflow traps.

Result mux
- mfhi (opcode 0, func 010000) → HI.
- mflo (func 010010) → LO.
- Else the ALU result.

Store formatting
- sw: wen 1111.
- sh: addr[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
- sb: 0001 << addr[1:0]; wdata = {4{rt[7:0]}}.
- Loads: en=1, wen=0000.
- Address low bits are used unchecked; there is no misalignment exception.

HI/LO
- HI and LO reset to 0.
- Writes commit only at an edge with stall[3]=0 and valid write data.
- mthi: HI = rdata1. mtlo: LO = rdata1.
- mult/multu: {HI,LO} = signed/unsigned 64-bit product, single cycle.
- div/divu: HI = remainder, LO = quotient, written at the DONE edge.

Divider FSM (IDLE, BUSY, DONE)
- IDLE → BUSY when a div/divu is in EX; operand magnitudes are latched and the counter is set to 0.
- BUSY: one restoring step per cycle; after 32 steps → DONE.
- DONE → IDLE on an edge with stall[2]=0.
- stallreq_for_ex = div/divu in EX and state ≠ DONE.
- Latency: 1 IDLE + 32 BUSY cycles stalled; result valid in the DONE cycle (34th).
- Signed divide: quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- Divisor 0: LO = 32'hFFFFFFFF, HI = dividend, for both signed and unsigned.
- Reset mid-divide: FSM returns to IDLE; HI/LO are not modified.
- A bubble entering EX while BUSY cannot occur, because stallreq holds EX. The FSM ignores the pipeline register contents once it is BUSY.

Forwarding
- ex_to_id_bus.is_load = sel_rf_res.
- All outputs are 0 while the pipeline register holds reset/bubble content, except that the inst=0 bubble yields rf_we=0.

Optional Feature:
- Macro: EX_DIV_ZERO_FAST_EN.
- Defined: a zero divisor takes IDLE → DONE directly (1 stall cycle, result in cycle 2).
- Undefined: a zero divisor runs the full 32 iterations.
- Results are identical in both cases.

Decomposition:
- Shared defines (lib/defines.vh): the three bus widths, StallBus=6, Stop=1'b1, NoStop=1'b0, and the alu_op bit indices.
- Sub-module div_iter: FSM, counter and 64-bit remainder/quotient shift register.
- div_iter interface: start, signed_op, op_a, op_b → done, quotient, remainder.
- div_iter also honours EX_DIV_ZERO_FAST_EN.

Test Plan:
- addiu: rdata1=5, imm=0xFFFF, add+src2[1] → result 4, data_sram_en=0, ex_to_id rf_we=1.
- sb to addr 0x1003, rt=0x12345678 → wen 1000, wdata 0x78787878. sh to 0x1002 → wen 1100, wdata 0x56785678.
- div −7 by 2 → stallreq high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. mfhi next → result 0xFFFFFFFF.
- divu 7 by 0 → LO=0xFFFFFFFF, HI=7. Stall length is 33 cycles, or 1 with EX_DIV_ZERO_FAST_EN.
- Assert rst low at BUSY step 10 → stallreq=0 and all outputs 0 immediately; after release the FSM is IDLE and HI/LO=0.
- mult 0xFFFFFFFF × 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu → HI=1, LO=0xFFFFFFFE. Hold stall[3]=1 → HI/LO unchanged until released.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, ALU op bit positions and decode constants for
// the execute stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 82;
  localparam int EX_TO_ID_WD  = 39;
  localparam int STALL_BUS_WD = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // alu_op bit positions, MSB (add) to LSB (lui)
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider (32 steps) with signed/unsigned support.
// EX_DIV_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        signed_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

`ifdef EX_DIV_ZERO_FAST_EN
  localparam logic ZERO_FAST = 1'b1;
`else
  localparam logic ZERO_FAST = 1'b0;
`endif

  logic [1:0]  state_reg;
  logic [4:0]  cnt_reg;
  logic [63:0] rq_reg;
  logic [31:0] b_mag_reg;
  logic [31:0] a_raw_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        zero_reg;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] trial;
  logic [63:0] rq_step;

  assign a_neg = signed_op & op_a[31];
  assign b_neg = signed_op & op_b[31];
  assign a_mag = a_neg ? (32'd0 - op_a) : op_a;
  assign b_mag = b_neg ? (32'd0 - op_b) : op_b;

  // Partial remainder shifted left by one, minus the divisor; the top bit is the borrow.
  assign trial   = rq_reg[63:31] - {1'b0, b_mag_reg};
  assign rq_step = trial[32] ? {rq_reg[62:0], 1'b0} : {trial[31:0], rq_reg[30:0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      rq_reg    <= '0;
      b_mag_reg <= '0;
      a_raw_reg <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            rq_reg    <= {32'd0, a_mag};
            b_mag_reg <= b_mag;
            a_raw_reg <= op_a;
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
            zero_reg  <= (op_b == 32'd0);
            cnt_reg   <= '0;
            state_reg <= (ZERO_FAST && op_b == 32'd0) ? DIV_DONE : DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rq_reg  <= rq_step;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state_reg <= DIV_IDLE;
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

  assign done = (state_reg == DIV_DONE);

  // Zero divisor gives all-ones quotient and the untouched dividend as remainder.
  assign quotient  = zero_reg ? 32'hFFFF_FFFF :
                     (q_neg_reg ? (32'd0 - rq_reg[31:0]) : rq_reg[31:0]);
  assign remainder = zero_reg ? a_raw_reg :
                     (r_neg_reg ? (32'd0 - rq_reg[63:32]) : rq_reg[63:32]);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: pipeline register, ALU, data-SRAM request, HI/LO, mult/div.
// EX_DIV_ZERO_FAST_EN shortens zero-divisor divides inside div_iter.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic         stallreq_for_ex,
  output logic [81:0]  ex_to_mem_bus,
  output logic [38:0]  ex_to_id_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  id_to_ex_t ex_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      ex_reg <= '0;
    end else if (stall[2] == NO_STOP) begin
      ex_reg <= id_to_ex_bus;
    end
  end

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        special;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic        is_mult, is_multu, is_div, is_divu;

  assign opcode   = ex_reg.inst[31:26];
  assign func     = ex_reg.inst[5:0];
  assign special  = (opcode == OP_SPECIAL);
  assign is_mfhi  = special && func == FN_MFHI;
  assign is_mflo  = special && func == FN_MFLO;
  assign is_mthi  = special && func == FN_MTHI;
  assign is_mtlo  = special && func == FN_MTLO;
  assign is_mult  = special && func == FN_MULT;
  assign is_multu = special && func == FN_MULTU;
  assign is_div   = special && func == FN_DIV;
  assign is_divu  = special && func == FN_DIVU;

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] src1;
  logic [31:0] src2;

  assign imm_sext = sext16(ex_reg.inst[15:0]);
  assign imm_zext = {16'd0, ex_reg.inst[15:0]};

  assign src1 = ({32{ex_reg.sel_src1[0]}} & ex_reg.rdata1)
              | ({32{ex_reg.sel_src1[1]}} & ex_reg.pc)
              | ({32{ex_reg.sel_src1[2]}} & {27'd0, ex_reg.inst[10:6]});

  assign src2 = ({32{ex_reg.sel_src2[0]}} & ex_reg.rdata2)
              | ({32{ex_reg.sel_src2[1]}} & imm_sext)
              | ({32{ex_reg.sel_src2[2]}} & 32'd8)
              | ({32{ex_reg.sel_src2[3]}} & imm_zext);

  logic [31:0] sra_res;
  logic [31:0] alu_res;

  assign sra_res = $unsigned($signed(src2) >>> src1[4:0]);

  always_comb begin
    alu_res = '0;
    if (ex_reg.alu_op[ALU_ADD])  alu_res = alu_res | (src1 + src2);
    if (ex_reg.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
    if (ex_reg.alu_op[ALU_SLT])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
    if (ex_reg.alu_op[ALU_SLTU]) alu_res = alu_res | {31'd0, src1 < src2};
    if (ex_reg.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
    if (ex_reg.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
    if (ex_reg.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
    if (ex_reg.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
    if (ex_reg.alu_op[ALU_SLL])  alu_res = alu_res | (src2 << src1[4:0]);
    if (ex_reg.alu_op[ALU_SRL])  alu_res = alu_res | (src2 >> src1[4:0]);
    if (ex_reg.alu_op[ALU_SRA])  alu_res = alu_res | sra_res;
    if (ex_reg.alu_op[ALU_LUI])  alu_res = alu_res | {src2[15:0], 16'd0};
  end

  // Low 64 bits of the product of sign- or zero-extended operands.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign mul_a   = is_mult ? {{32{ex_reg.rdata1[31]}}, ex_reg.rdata1} : {32'd0, ex_reg.rdata1};
  assign mul_b   = is_mult ? {{32{ex_reg.rdata2[31]}}, ex_reg.rdata2} : {32'd0, ex_reg.rdata2};
  assign product = mul_a * mul_b;

  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div | is_divu),
    .ack       (stall[2] == NO_STOP),
    .signed_op (is_div),
    .op_a      (ex_reg.rdata1),
    .op_b      (ex_reg.rdata2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign stallreq_for_ex = (is_div | is_divu) & ~div_done;

  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (stall[3] == NO_STOP) begin
      if ((is_div | is_divu) && div_done) begin
        hi_reg <= div_rem;
        lo_reg <= div_quo;
      end else if (is_mult | is_multu) begin
        hi_reg <= product[63:32];
        lo_reg <= product[31:0];
      end else begin
        if (is_mthi) hi_reg <= ex_reg.rdata1;
        if (is_mtlo) lo_reg <= ex_reg.rdata1;
      end
    end
  end

  logic [31:0] result;
  assign result = is_mfhi ? hi_reg : (is_mflo ? lo_reg : alu_res);

  logic is_store;
  assign is_store       = |ex_reg.ram_wen;
  assign data_sram_en   = ex_reg.ram_en;
  assign data_sram_addr = ex_reg.rdata1 + imm_sext;

  always_comb begin
    data_sram_wen = 4'b0000;
    if (ex_reg.ram_en && is_store) begin
      case (opcode)
        OP_SB:   data_sram_wen = 4'b0001 << data_sram_addr[1:0];
        OP_SH:   data_sram_wen = data_sram_addr[1] ? 4'b1100 : 4'b0011;
        default: data_sram_wen = 4'b1111;
      endcase
    end
  end

  // Byte/halfword stores replicate the low lanes of rt across the word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wdata_lane
      assign data_sram_wdata[8*gi +: 8] =
        (opcode == OP_SB) ? ex_reg.rdata2[7:0] :
        (opcode == OP_SH) ? ex_reg.rdata2[8*(gi%2) +: 8] :
                            ex_reg.rdata2[8*gi +: 8];
    end
  endgenerate

  assign ex_to_mem_bus = {ex_reg.pc, opcode, ex_reg.ram_en, data_sram_wen,
                          ex_reg.sel_rf_res, ex_reg.rf_we, ex_reg.rf_waddr, result};
  assign ex_to_id_bus  = {ex_reg.sel_rf_res, ex_reg.rf_we, ex_reg.rf_waddr, result};

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], ex_reg.inst[25:16]};

endmodule
